// File: rtl/denise_clk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : denise_clk_pkg
// Description : Shared helpers for the bus clock regenerator: derived tap
//               positions, counter widths and the per-channel status record.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package denise_clk_pkg;

    // Ceiling log2, never less than 1 so a counter always has a bit.
    function automatic int f_clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r = r + 1;
            x = x >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // H: eighth-period tap (quarter of a half-period).
    function automatic int f_h(input int half_per);
        return half_per / 4;
    endfunction

    // Q: quarter-period tap (half of a half-period).
    function automatic int f_q(input int half_per);
        return half_per / 2;
    endfunction

    // DL: delay line length, just long enough for the 3H edge detector.
    function automatic int f_dl(input int half_per);
        return 3 * (half_per / 4) + 2;
    endfunction

    // Width of the half-period counter, which saturates at HALF_PER+TOL+1.
    function automatic int f_cnt_w(input int half_per, input int tol);
        return f_clog2(half_per + tol + 2);
    endfunction

    typedef struct packed {
        logic lvl;
        logic q_lvl;
        logic locked;
    } ch_status_t;

endpackage
`default_nettype wire

// File: rtl/bus_clk_regen_ch.sv
`default_nettype none
// ============================================================================
// Module      : bus_clk_regen_ch
// Description : One channel: synchroniser, tapped delay line, registered edge
//               strobes and (with BUS_CLK_REGEN_LOCK_EN) a half-period lock
//               monitor. Without the macro, locked is 1 after reset release.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module bus_clk_regen_ch
    import denise_clk_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int HALF_PER    = 8,
    parameter int TOL         = 1,
    parameter int LOCK_CNT    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_lvl,
    output logic o_q_lvl,
    output logic o_edge_any,
    output logic o_edge_rise,
    output logic o_edge_q,
    output logic o_edge_h,
    output logic o_locked
);

    localparam int c_H  = f_h(HALF_PER);
    localparam int c_Q  = f_q(HALF_PER);
    localparam int c_DL = f_dl(HALF_PER);

    // Elaboration-time guard against configurations the tap layout cannot serve.
    if ((SYNC_STAGES < 2) || (HALF_PER < 4) || ((HALF_PER % 4) != 0) ||
        (TOL < 0) || (TOL >= HALF_PER) || (LOCK_CNT < 1)) begin : g_bad_cfg
        $error("bus_clk_regen_ch: illegal parameter combination");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic [c_DL-1:0]        r_dl;
    logic                   r_edge_any;
    logic                   r_edge_rise;
    logic                   r_edge_q;
    logic                   r_edge_h;
    logic                   r_locked;

    // Synchroniser feeding the delay line; dl[0] is the newest sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_dl   <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_dl   <= {r_dl[c_DL-2:0], r_sync[SYNC_STAGES-1]};
        end
    end

    // Registered edge strobes taken at tap 0, tap Q and taps H / 3H.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge_any  <= 1'b0;
            r_edge_rise <= 1'b0;
            r_edge_q    <= 1'b0;
            r_edge_h    <= 1'b0;
        end else begin
            r_edge_any  <= r_dl[0] ^ r_dl[1];
            r_edge_rise <= r_dl[0] & ~r_dl[1];
            r_edge_q    <= r_dl[c_Q] ^ r_dl[c_Q+1];
            r_edge_h    <= (r_dl[c_H] ^ r_dl[c_H+1]) | (r_dl[3*c_H] ^ r_dl[3*c_H+1]);
        end
    end

`ifdef BUS_CLK_REGEN_LOCK_EN
    localparam int c_CW = f_cnt_w(HALF_PER, TOL);
    localparam int c_GW = f_clog2(LOCK_CNT + 1);
    localparam logic [c_CW-1:0] c_SAT  = c_CW'(HALF_PER + TOL + 1);
    localparam logic [c_CW-1:0] c_LO   = c_CW'(HALF_PER - TOL);
    localparam logic [c_CW-1:0] c_HI   = c_CW'(HALF_PER + TOL);
    localparam logic [c_GW-1:0] c_LOCK = c_GW'(LOCK_CNT);

    logic [c_CW-1:0] r_cnt;
    logic [c_GW-1:0] r_good;
    logic            r_armed;
    logic            w_ev;
    logic            w_in_tol;

    assign w_ev     = r_dl[0] ^ r_dl[1];
    // A saturated count is above c_HI, so an edge arriving then is a bad interval.
    assign w_in_tol = (r_cnt >= c_LO) && (r_cnt <= c_HI);

    // Half-period monitor: measure edge spacing, count good intervals, drop on bad or timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_good   <= '0;
            r_armed  <= 1'b0;
            r_locked <= 1'b0;
        end else begin
            if (r_good == c_LOCK) begin
                r_locked <= 1'b1;
            end
            if (w_ev) begin
                r_cnt <= c_CW'(1);
                if (!r_armed) begin
                    r_armed <= 1'b1;
                end else if (w_in_tol) begin
                    if (r_good != c_LOCK) begin
                        r_good <= r_good + 1'b1;
                    end
                end else begin
                    r_good   <= '0;
                    r_locked <= 1'b0;
                end
            end else if (r_cnt == c_SAT) begin
                r_good   <= '0;
                r_armed  <= 1'b0;
                r_locked <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
`else
    // No monitor: report lock from the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked <= 1'b0;
        end else begin
            r_locked <= 1'b1;
        end
    end
`endif

    assign o_lvl       = r_dl[0];
    assign o_q_lvl     = r_dl[c_Q];
    assign o_edge_any  = r_edge_any;
    assign o_edge_rise = r_edge_rise;
    assign o_edge_q    = r_edge_q;
    assign o_edge_h    = r_edge_h;
    assign o_locked    = r_locked;

endmodule
`default_nettype wire

// File: rtl/bus_clk_regen.sv
`default_nettype none
// ============================================================================
// Module      : bus_clk_regen
// Description : Oversamples NUM_CH asynchronous bus clocks in the fast clock
//               domain and regenerates level, quadrature level, edge strobes
//               and a lock flag per channel. Lock monitor is built only when
//               BUS_CLK_REGEN_LOCK_EN is defined.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module bus_clk_regen
    import denise_clk_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int HALF_PER    = 8,
    parameter int TOL         = 1,
    parameter int LOCK_CNT    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] async_in,
    output logic [NUM_CH-1:0] lvl,
    output logic [NUM_CH-1:0] q_lvl,
    output logic [NUM_CH-1:0] edge_any,
    output logic [NUM_CH-1:0] edge_rise,
    output logic [NUM_CH-1:0] edge_q,
    output logic [NUM_CH-1:0] edge_h,
    output logic [NUM_CH-1:0] locked
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ch_status_t w_st;

        bus_clk_regen_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .HALF_PER    (HALF_PER),
            .TOL         (TOL),
            .LOCK_CNT    (LOCK_CNT)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_async     (async_in[g]),
            .o_lvl       (w_st.lvl),
            .o_q_lvl     (w_st.q_lvl),
            .o_edge_any  (edge_any[g]),
            .o_edge_rise (edge_rise[g]),
            .o_edge_q    (edge_q[g]),
            .o_edge_h    (edge_h[g]),
            .o_locked    (w_st.locked)
        );

        assign lvl[g]    = w_st.lvl;
        assign q_lvl[g]  = w_st.q_lvl;
        assign locked[g] = w_st.locked;
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_clk_regen.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_clk_regen
// Description : Randomised scoreboard bench for bus_clk_regen. Expected
//               outputs come from the raw input sample history (delays in
//               whole clocks) and an interval-based lock model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_clk_regen;

    localparam int NUM_CH = 2;
    localparam int SS     = 2;
    localparam int HP     = 8;
    localparam int TOL    = 1;
    localparam int LC     = 4;
    localparam int QD     = HP / 2;
    localparam int HD     = HP / 4;
    localparam int SAT    = HP + TOL + 1;
    localparam int MAXC   = 4096;

    logic              clk      = 1'b0;
    logic              rst_n    = 1'b0;
    logic [NUM_CH-1:0] async_in = '0;
    logic [NUM_CH-1:0] lvl, q_lvl, edge_any, edge_rise, edge_q, edge_h, locked;

    bus_clk_regen #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SS),
        .HALF_PER    (HP),
        .TOL         (TOL),
        .LOCK_CNT    (LC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .async_in  (async_in),
        .lvl       (lvl),
        .q_lvl     (q_lvl),
        .edge_any  (edge_any),
        .edge_rise (edge_rise),
        .edge_q    (edge_q),
        .edge_h    (edge_h),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int                n;
        logic [NUM_CH-1:0] lvl;
        logic [NUM_CH-1:0] q_lvl;
        logic [NUM_CH-1:0] ea;
        logic [NUM_CH-1:0] er;
        logic [NUM_CH-1:0] eq;
        logic [NUM_CH-1:0] eh;
        logic [NUM_CH-1:0] lk;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Input sampled at each clock edge; everything up to last_rst reads as 0.
    logic [NUM_CH-1:0] samp [0:MAXC-1];
    int cyc      = 0;
    int last_rst = 0;

    // Lock model: time of last edge, armed flag, good-interval run, lock flag.
    int m_anchor [NUM_CH];
    bit m_armed  [NUM_CH];
    int m_good   [NUM_CH];
    bit m_locked [NUM_CH];

    // Stimulus: cycles until next toggle and the range new intervals are drawn from.
    int cd [NUM_CH];
    int lo [NUM_CH];
    int hi [NUM_CH];

    function automatic logic [NUM_CH-1:0] s(input int j);
        if (j <= last_rst) return '0;
        return samp[j];
    endfunction

    task automatic chk(input string nm, input int n, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at edge %0d: got %b, expected %b", nm, n, act, exp);
        end
    endtask

    task automatic setp(input int l0, input int h0, input int l1, input int h1);
        lo[0] = l0; hi[0] = h0;
        lo[1] = l1; hi[1] = h1;
    endtask

    // Reference model for the state after edge m.
    task automatic model_edge(input bit rst);
        exp_t              e;
        logic [NUM_CH-1:0] p1, p2, c1, c2, d1, d2, h1, h2, k1, k2;
        int                m;
        int                el;
        int                dev;
        bit                ev;
        bit                nl;
        m = cyc;
        if (rst) begin
            last_rst = m;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                m_anchor[ch] = m;
                m_armed[ch]  = 1'b0;
                m_good[ch]   = 0;
                m_locked[ch] = 1'b0;
            end
        end else begin
            p1 = s(m - 1 - SS);
            p2 = s(m - 2 - SS);
            for (int ch = 0; ch < NUM_CH; ch++) begin
                ev  = p1[ch] ^ p2[ch];
                el  = (m - 1 - m_anchor[ch] < SAT) ? (m - 1 - m_anchor[ch]) : SAT;
                dev = (el > HP) ? (el - HP) : (HP - el);
                nl  = m_locked[ch] | (m_good[ch] == LC);
                if (ev) begin
                    m_anchor[ch] = m - 1;
                    if (!m_armed[ch]) begin
                        m_armed[ch] = 1'b1;
                    end else if (dev <= TOL) begin
                        m_good[ch] = (m_good[ch] < LC) ? m_good[ch] + 1 : LC;
                    end else begin
                        m_good[ch] = 0;
                        nl = 1'b0;
                    end
                end else if (el == SAT) begin
                    m_armed[ch] = 1'b0;
                    m_good[ch]  = 0;
                    nl = 1'b0;
                end
                m_locked[ch] = nl;
            end
        end
        c1 = s(m - SS - 1);          c2 = s(m - SS - 2);
        d1 = s(m - SS - 1 - QD);     d2 = s(m - SS - 2 - QD);
        h1 = s(m - SS - 1 - HD);     h2 = s(m - SS - 2 - HD);
        k1 = s(m - SS - 1 - 3 * HD); k2 = s(m - SS - 2 - 3 * HD);
        e.n     = m;
        e.lvl   = s(m - SS);
        e.q_lvl = s(m - SS - QD);
        e.ea    = c1 ^ c2;
        e.er    = c1 & ~c2;
        e.eq    = d1 ^ d2;
        e.eh    = (h1 ^ h2) | (k1 ^ k2);
        for (int ch = 0; ch < NUM_CH; ch++) begin
`ifdef BUS_CLK_REGEN_LOCK_EN
            e.lk[ch] = m_locked[ch];
`else
            e.lk[ch] = !rst;
`endif
        end
        sb_q.push_back(e);
    endtask

    // One clock of stimulus: drive inputs between edges, then record the expectation.
    task automatic step(input bit rst);
        @(negedge clk);
        if (rst) begin
            async_in = '0;
            for (int ch = 0; ch < NUM_CH; ch++) cd[ch] = HP;
            if (rst_n) begin
                rst_n = 1'b0;
                #1;
                chk("reset_immediate", cyc,
                    {2'b00, lvl, q_lvl, edge_any, edge_rise, edge_q, edge_h, locked}, 16'h0);
            end
        end else begin
            rst_n = 1'b1;
            for (int ch = 0; ch < NUM_CH; ch++) begin
                if (hi[ch] > 0) begin
                    cd[ch] = cd[ch] - 1;
                    if (cd[ch] <= 0) begin
                        async_in[ch] = ~async_in[ch];
                        cd[ch] = int'($urandom_range(hi[ch], lo[ch]));
                    end
                end
            end
        end
        cyc = cyc + 1;
        samp[cyc] = async_in;
        model_edge(rst);
    endtask

    // Monitor: every edge the DUT presents a new output set; compare it with the queue head.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("lvl",       e.n, 16'(lvl),       16'(e.lvl));
                chk("q_lvl",     e.n, 16'(q_lvl),     16'(e.q_lvl));
                chk("edge_any",  e.n, 16'(edge_any),  16'(e.ea));
                chk("edge_rise", e.n, 16'(edge_rise), 16'(e.er));
                chk("edge_q",    e.n, 16'(edge_q),    16'(e.eq));
                chk("edge_h",    e.n, 16'(edge_h),    16'(e.eh));
                chk("locked",    e.n, 16'(locked),    16'(e.lk));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit prev;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_anchor[ch] = 0; m_armed[ch] = 1'b0; m_good[ch] = 0; m_locked[ch] = 1'b0;
        end
        setp(8, 8, 8, 8);
        cd[0] = 8; cd[1] = 5;
        repeat (4) step(1'b1);

        // Lock acquire on steady half-period of 8.
        repeat (80) step(1'b0);
        // Jitter within tolerance keeps lock.
        setp(7, 9, 7, 9);
        repeat (120) step(1'b0);
        // Glitch train on ch0, then relock.
        setp(3, 3, 8, 8);
        cd[0] = 1;
        repeat (6) step(1'b0);
        setp(8, 8, 8, 8);
        repeat (60) step(1'b0);
        // ch1 stuck, then recovers.
        hi[1] = 0;
        repeat (25) step(1'b0);
        setp(8, 8, 8, 8);
        repeat (70) step(1'b0);
        // Reset between a falling toggle on ch0 and its strobe.
        for (int i = 0; i < 40; i++) begin
            prev = async_in[0];
            step(1'b0);
            if (prev && !async_in[0]) break;
        end
        step(1'b0);
        repeat (3) step(1'b1);
        repeat (30) step(1'b0);
        // Independence: ch1 runs too slow to ever lock.
        setp(8, 8, 12, 12);
        repeat (150) step(1'b0);
        // Random intervals, including just in and just out of tolerance.
        setp(2, 14, 2, 14);
        repeat (300) step(1'b0);

        @(posedge clk);
        #2;
        chk("scoreboard_drained", cyc, 16'(sb_q.size()), 16'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
